bool_fn_sweep: RTL and testbench

Programmable NUM_IN-input Boolean function unit. The function is a runtime-loadable truth table; the default is Y = (ab)' + cd' with index {a,b,c,d}.
Two modes share one registered output stage with a valid/ready handshake:
- Stream: evaluate caller-supplied vectors.
- Sweep: walk all 2^NUM_IN input combinations exhaustively and count the 1s.
Sits between lab stimulus logic (switches/UART) and display or checker logic.

---
 rtl/bool_fn_pkg.sv | 27 ++
 rtl/bool_fn_out_stage.sv | 41 ++++
 rtl/bool_fn_sweep.sv | 141 ++++++++++++++
 tb/tb_bool_fn_sweep.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bool_fn_pkg.sv
// Shared definitions for the programmable Boolean function unit.
//   - state_e       : sequencer states (IDLE, SWEEP, DRAIN)
//   - TT_*          : ready-made 4-input truth tables, index {a,b,c,d}
//   - tt_bit        : reads one truth-table entry for a 4-input vector
package bool_fn_pkg;

  localparam int unsigned TT4_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Y = (ab)' + cd'
  localparam logic [TT4_W-1:0] TT_NAND_AB_OR_C_NOT_D = 16'h4FFF;
  // Y = abcd
  localparam logic [TT4_W-1:0] TT_AND4 = 16'h8000;
  // Y = a ^ b ^ c ^ d
  localparam logic [TT4_W-1:0] TT_XOR4 = 16'h6996;

  // Looks up one entry of a 4-input truth table; bit i is Y for vector i.
  function automatic logic tt_bit(input logic [TT4_W-1:0] tt, input logic [3:0] vec);
    return tt[vec];
  endfunction

endpackage

// File: rtl/bool_fn_out_stage.sv
// Single-entry valid/ready output register.
//   load         : capture load_vec/load_y this edge (caller only asserts it
//                  when slot_free_c is high)
//   out_ready    : downstream accepts the held item
//   out_valid    : item held
//   out_vec/out_y: held item, stable while out_valid && !out_ready
//   slot_free_c  : register can take a new item this cycle
module bool_fn_out_stage #(
  parameter int unsigned NUM_IN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [NUM_IN-1:0] load_vec,
  input  logic              load_y,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [NUM_IN-1:0] out_vec,
  output logic              out_y,
  output logic              slot_free_c
);

  // Empty, or being drained this cycle, so a new item can land in its place.
  assign slot_free_c = !out_valid || out_ready;

  // Load wins over consume so back-to-back items keep full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_y     <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_vec   <= load_vec;
      out_y     <= load_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bool_fn_sweep.sv
// Programmable NUM_IN-input Boolean function unit with a runtime-loadable
// truth table. Stream mode evaluates caller vectors; sweep mode walks every
// input combination in order and counts the 1 results.
//   clk, rst_n           : clock, async active-low reset
//   tt_we, tt_wdata      : truth-table load (honoured only while idle)
//   in_valid/in_ready    : stream vector handshake, in_vec is the vector
//   start                : sweep request, level sampled, priority over stream
//   busy                 : sweep in progress
//   out_valid/out_ready  : result handshake, out_vec/out_y is the result
//   sweep_done           : one-cycle pulse when a sweep finishes
//   ones_cnt             : number of 1 results in the last sweep
module bool_fn_sweep
  import bool_fn_pkg::*;
#(
  parameter int unsigned                NUM_IN     = 4,
  parameter logic [(1 << NUM_IN)-1:0]   TT_DEFAULT = 16'h4FFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tt_we,
  input  logic [(1 << NUM_IN)-1:0]   tt_wdata,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_IN-1:0]          in_vec,
  input  logic                       start,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_IN-1:0]          out_vec,
  output logic                       out_y,
  output logic                       sweep_done,
  output logic [NUM_IN:0]            ones_cnt
);

  localparam int unsigned NUM_VEC = 1 << NUM_IN;
  localparam int unsigned CNT_W   = NUM_IN;
  localparam int unsigned ONES_W  = NUM_IN + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_VEC - 1);

  state_e             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [ONES_W-1:0]  ones_d;
  logic [NUM_VEC-1:0] tt, tt_d;
  logic               done_d;

  logic               slot_free_c;
  logic               stream_fire_c;
  logic               sweep_fire_c;
  logic               load_c;
  logic [NUM_IN-1:0]  load_vec_c;
  logic               load_y_c;

  // Stream input is accepted only when idle, no sweep is being requested and
  // the output register can take the result.
  assign in_ready      = (state == IDLE) && !start && slot_free_c;
  assign stream_fire_c = in_valid && in_ready;
  assign sweep_fire_c  = (state == SWEEP) && slot_free_c;
  assign load_c        = stream_fire_c || sweep_fire_c;
  assign busy          = (state != IDLE);

  // During a sweep the counter drives the lookup, so in_vec (possibly X when
  // in_valid is low) never reaches the output register.
  assign load_vec_c = (state == SWEEP) ? cnt : in_vec;
  assign load_y_c   = tt[load_vec_c];

  // Next-state and datapath control.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ones_d  = ones_cnt;
    tt_d    = tt;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        // Table writes land next edge; a same-cycle stream lookup sees the old table.
        if (tt_we) begin
          tt_d = tt_wdata;
        end
        if (start) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        // Backpressure stalls the counter: advance only when a result is emitted.
        if (slot_free_c) begin
          ones_d = ones_cnt + ONES_W'(load_y_c);
          if (cnt == CNT_LAST) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        // Completion is flagged once the final result has left or is leaving.
        if (slot_free_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, table and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      ones_cnt   <= '0;
      tt         <= TT_DEFAULT;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      ones_cnt   <= ones_d;
      tt         <= tt_d;
      sweep_done <= done_d;
    end
  end

  bool_fn_out_stage #(
    .NUM_IN (NUM_IN)
  ) u_out_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_c),
    .load_vec    (load_vec_c),
    .load_y      (load_y_c),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_vec     (out_vec),
    .out_y       (out_y),
    .slot_free_c (slot_free_c)
  );

endmodule

// File: tb/tb_bool_fn_sweep.sv
// Self-checking bench for bool_fn_sweep (NUM_IN = 4, default table 16'h4FFF).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bool_fn_sweep;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tt_we;
  logic [15:0] tt_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_vec;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_vec;
  logic        out_y;
  logic        sweep_done;
  logic [4:0]  ones_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bool_fn_sweep dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tt_we      (tt_we),
    .tt_wdata   (tt_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vec     (in_vec),
    .start      (start),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .out_y      (out_y),
    .sweep_done (sweep_done),
    .ones_cnt   (ones_cnt)
  );

  typedef struct {
    logic [3:0] vec;
    logic       y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One stream transaction with out_ready high; in_vec goes X afterwards.
  task automatic stream_one(input string name, input logic [3:0] v, input logic exp_y);
    in_valid  = 1'b1;
    in_vec    = v;
    out_ready = 1'b1;
    #1;
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = 4'bxxxx;
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check({name, " vec"}, 32'(out_vec), 32'(v));
    check({name, " y"}, 32'(out_y), 32'(exp_y));
    @(negedge clk);
    check({name, " drained"}, 32'(out_valid), 32'd0);
  endtask

  vec_t        tbl[7];
  logic [15:0] tt_exp;
  int          seen;
  int          done_cnt;
  bit          found;
  bit          finished;

  initial begin
    // Expected results for the default table (ab)' + cd', index {a,b,c,d}.
    tbl[0] = '{4'b0000, 1'b1};
    tbl[1] = '{4'b1100, 1'b0};
    tbl[2] = '{4'b1101, 1'b0};
    tbl[3] = '{4'b1110, 1'b1};
    tbl[4] = '{4'b1111, 1'b0};
    tbl[5] = '{4'b0101, 1'b1};
    tbl[6] = '{4'b1011, 1'b1};

    rst_n = 1'b0; tt_we = 1'b0; tt_wdata = '0; in_valid = 1'b0;
    in_vec = 4'bxxxx; start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ones_cnt", 32'(ones_cnt), 32'd0);
    check("rst sweep_done", 32'(sweep_done), 32'd0);
    check("rst out_vec", 32'(out_vec), 32'd0);
    check("rst out_y", 32'(out_y), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream vectors, one result per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_vec   = tbl[i].vec;
      @(negedge clk);
      check($sformatf("stream%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d vec", i), 32'(out_vec), 32'(tbl[i].vec));
      check($sformatf("stream%0d y", i), 32'(out_y), 32'(tbl[i].y));
    end
    in_valid = 1'b0;
    in_vec   = 4'bxxxx;
    @(negedge clk);
    check("stream idle valid", 32'(out_valid), 32'd0);

    // Backpressure: held item stays put, new input refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 4'b1100;
    @(negedge clk);
    in_vec = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d vec", i), 32'(out_vec), 32'hC);
      check($sformatf("bp%0d y", i), 32'(out_y), 32'd0);
      check($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_vec    = 4'bxxxx;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp consumed", 32'(out_valid), 32'd0);
    check("bp in_ready", 32'(in_ready), 32'd1);

    // Sweep with default table and out_ready high: exact cycle timing.
    tt_exp = 16'h4FFF;
    start  = 1'b1;
    #1;
    check("sweep start in_ready", 32'(in_ready), 32'd0);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        check("sweep c1 busy", 32'(busy), 32'd1);
        check("sweep c1 valid", 32'(out_valid), 32'd0);
      end else if (c <= 17) begin
        check($sformatf("sweep c%0d valid", c), 32'(out_valid), 32'd1);
        check($sformatf("sweep c%0d vec", c), 32'(out_vec), 32'(c - 2));
        check($sformatf("sweep c%0d y", c), 32'(out_y), 32'(tt_exp[c - 2]));
      end
      if (c == 18) begin
        check("sweep c18 done", 32'(sweep_done), 32'd1);
        check("sweep c18 valid", 32'(out_valid), 32'd0);
        check("sweep c18 busy", 32'(busy), 32'd0);
      end else begin
        check($sformatf("sweep c%0d no done", c), 32'(sweep_done), 32'd0);
      end
    end
    check("sweep ones_cnt", 32'(ones_cnt), 32'd13);

    // Load AND4, then sweep with random stalls; mid-sweep write and start ignored.
    tt_we    = 1'b1;
    tt_wdata = 16'h8000;
    @(negedge clk);
    tt_we = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("and4 busy", 32'(busy), 32'd1);
    seen = 0;
    done_cnt = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (cyc == 3) begin
        tt_we = 1'b1; tt_wdata = 16'hFFFF; start = 1'b1;
      end else begin
        tt_we = 1'b0; start = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        check($sformatf("and4 item%0d vec", seen), 32'(out_vec), 32'(seen));
        check($sformatf("and4 item%0d y", seen), 32'(out_y), 32'(seen == 15));
        seen++;
      end
      @(negedge clk);
      if (sweep_done) begin
        done_cnt++;
        finished = 1'b1;
      end
    end
    tt_we = 1'b0; start = 1'b0;
    out_ready = 1'b1;
    check("and4 item count", 32'(seen), 32'd16);
    check("and4 done count", 32'(done_cnt), 32'd1);
    check("and4 ones_cnt", 32'(ones_cnt), 32'd1);
    @(negedge clk);
    check("and4 done pulse width", 32'(sweep_done), 32'd0);
    check("and4 idle", 32'(busy), 32'd0);
    check("and4 ones_cnt hold", 32'(ones_cnt), 32'd1);
    stream_one("and4 tt 1111", 4'b1111, 1'b1);
    stream_one("and4 tt 1110", 4'b1110, 1'b0);

    // Reset in the middle of a sweep.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 40 && !found; cyc++) begin
      @(negedge clk);
      if (out_valid && out_vec == 4'd7) found = 1'b1;
    end
    check("midrst reached vec7", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_vec", 32'(out_vec), 32'd0);
    check("midrst out_y", 32'(out_y), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ones_cnt", 32'(ones_cnt), 32'd0);
    check("midrst sweep_done", 32'(sweep_done), 32'd0);
    done_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (sweep_done) done_cnt++;
    end
    check("midrst no done pulse", 32'(done_cnt), 32'd0);
    check("midrst idle", 32'(busy), 32'd0);
    stream_one("midrst tt 0000", 4'b0000, 1'b1);
    stream_one("midrst tt 1100", 4'b1100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
